// File: rtl/pipeline_stall_controller_if.sv
// Hazard/stall signal bundle between the pipeline datapath (master) and the stall controller (slave).
interface pipeline_stall_controller_if #(
  parameter int COUNTER_WIDTH = 16
);
  logic                     idExMemRead;
  logic [4:0]               idExRt;
  logic [4:0]               ifIdRs;
  logic [4:0]               ifIdRt;
  logic                     ifIdUsesRt;
  logic                     mulDivIssue;
  logic                     branchTaken;
  logic                     clearStallCount;
  logic                     pcWrite;
  logic                     ifIdWrite;
  logic                     bubbleInstruction;
  logic                     ifIdFlush;
  logic                     mulDivBusy;
  logic [1:0]               state;
  logic [COUNTER_WIDTH-1:0] stallCycles;

  modport master (
    output idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
           mulDivIssue, branchTaken, clearStallCount,
    input  pcWrite, ifIdWrite, bubbleInstruction, ifIdFlush,
           mulDivBusy, state, stallCycles
  );

  modport slave (
    input  idExMemRead, idExRt, ifIdRs, ifIdRt, ifIdUsesRt,
           mulDivIssue, branchTaken, clearStallCount,
    output pcWrite, ifIdWrite, bubbleInstruction, ifIdFlush,
           mulDivBusy, state, stallCycles
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: load-use stalls, mul/div issue waits, branch flushes; Moore registered outputs.
// Optional stall-cycle counter enabled by defining STALL_COUNTER_EN.
module pipeline_stall_controller #(
  parameter int MULDIV_LATENCY = 4,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  pipeline_stall_controller_if.slave   ctl
);

  typedef enum logic [1:0] {
    RUN         = 2'b00,
    LOAD_STALL  = 2'b01,
    MULDIV_WAIT = 2'b10,
    FLUSH       = 2'b11
  } state_e;

  localparam logic [3:0] WAIT_INIT = 4'(MULDIV_LATENCY - 1);

  state_e     state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       load_use;
  logic       pc_write_q, if_id_write_q, bubble_q, flush_q, busy_q;

  assign load_use = ctl.idExMemRead && (ctl.idExRt != 5'd0) &&
                    ((ctl.idExRt == ctl.ifIdRs) ||
                     (ctl.ifIdUsesRt && (ctl.idExRt == ctl.ifIdRt)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (ctl.branchTaken) begin
          state_d = FLUSH;
        end else if (ctl.mulDivIssue) begin
          state_d    = MULDIV_WAIT;
          wait_cnt_d = WAIT_INIT;
        end else if (load_use) begin
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = ctl.branchTaken ? FLUSH : RUN;
      MULDIV_WAIT: begin
        // A taken branch abandons the younger mul/div, so its remaining wait is dropped.
        if (ctl.branchTaken) begin
          state_d    = FLUSH;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      FLUSH: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      wait_cnt_q    <= 4'd0;
      pc_write_q    <= 1'b1;
      if_id_write_q <= 1'b1;
      bubble_q      <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      // Outputs are decoded from the next state so they are flops aligned with state_q.
      case (state_d)
        RUN: begin
          pc_write_q <= 1'b1; if_id_write_q <= 1'b1; bubble_q <= 1'b0;
          flush_q    <= 1'b0; busy_q        <= 1'b0;
        end
        LOAD_STALL: begin
          pc_write_q <= 1'b0; if_id_write_q <= 1'b0; bubble_q <= 1'b1;
          flush_q    <= 1'b0; busy_q        <= 1'b0;
        end
        MULDIV_WAIT: begin
          pc_write_q <= 1'b0; if_id_write_q <= 1'b0; bubble_q <= 1'b1;
          flush_q    <= 1'b0; busy_q        <= 1'b1;
        end
        FLUSH: begin
          pc_write_q <= 1'b1; if_id_write_q <= 1'b1; bubble_q <= 1'b1;
          flush_q    <= 1'b1; busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign ctl.pcWrite           = pc_write_q;
  assign ctl.ifIdWrite         = if_id_write_q;
  assign ctl.bubbleInstruction = bubble_q;
  assign ctl.ifIdFlush         = flush_q;
  assign ctl.mulDivBusy        = busy_q;
  assign ctl.state             = state_q;

`ifdef STALL_COUNTER_EN
  logic [COUNTER_WIDTH-1:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (ctl.clearStallCount) begin
      stall_cnt_q <= '0;
    end else if (((state_q == LOAD_STALL) || (state_q == MULDIV_WAIT)) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign ctl.stallCycles = stall_cnt_q;
`else
  logic unused_clear_stall_count;
  assign unused_clear_stall_count = ctl.clearStallCount;
  assign ctl.stallCycles          = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (MULDIV_LATENCY=4, COUNTER_WIDTH=16).
module tb_pipeline_stall_controller;

  localparam logic [1:0] S_RUN = 2'b00, S_LS = 2'b01, S_MD = 2'b10, S_FL = 2'b11;
`ifdef STALL_COUNTER_EN
  localparam int EXP_CNT = 5;
`else
  localparam int EXP_CNT = 0;
`endif

  typedef struct packed {
    logic       mr;
    logic [4:0] exrt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       mul;
    logic       br;
    logic [1:0] st;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [6:0] exp_q[$];
  stim_t seq[$];

  pipeline_stall_controller_if #(.COUNTER_WIDTH(16)) bus ();

  pipeline_stall_controller #(.MULDIV_LATENCY(4), .COUNTER_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  function automatic stim_t mk(logic mr, logic [4:0] exrt, logic [4:0] rs, logic [4:0] rt,
                               logic uses, logic mul, logic br, logic [1:0] st);
    return '{mr, exrt, rs, rt, uses, mul, br, st};
  endfunction

  function automatic stim_t idle(logic [1:0] st);
    return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, st);
  endfunction

  // Expected {state, pcWrite, ifIdWrite, bubble, flush, busy} for each state.
  function automatic logic [6:0] outv(logic [1:0] st);
    case (st)
      S_RUN:   return 7'b00_11000;
      S_LS:    return 7'b01_00100;
      S_MD:    return 7'b10_00101;
      default: return 7'b11_11110;
    endcase
  endfunction

  function automatic logic [6:0] obs();
    return {bus.state, bus.pcWrite, bus.ifIdWrite, bus.bubbleInstruction,
            bus.ifIdFlush, bus.mulDivBusy};
  endfunction

  task automatic apply(input stim_t s);
    bus.idExMemRead = s.mr;
    bus.idExRt      = s.exrt;
    bus.ifIdRs      = s.rs;
    bus.ifIdRt      = s.rt;
    bus.ifIdUsesRt  = s.uses;
    bus.mulDivIssue = s.mul;
    bus.branchTaken = s.br;
    exp_q.push_back(outv(s.st));
  endtask

  task automatic test_reset();
    apply(mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, S_RUN));
    bus.clearStallCount = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs() !== exp_q.pop_front()) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs(), outv(S_RUN));
    end
    checks++;
    if (bus.stallCycles !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", bus.stallCycles);
    end
    @(negedge clk);
    apply(idle(S_RUN));
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (obs() !== exp_q.pop_front()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", obs(), outv(S_RUN));
    end
  endtask

  task automatic test_load_use();
    seq = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, S_LS), idle(S_RUN), idle(S_RUN),
            mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, S_LS), idle(S_RUN),
            mk(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, S_RUN),
            mk(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, S_RUN),
            mk(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, S_RUN), idle(S_RUN)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL load_use[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_muldiv();
    seq = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_MD), idle(S_MD), idle(S_MD), idle(S_MD),
            idle(S_RUN), idle(S_RUN),
            mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, S_MD),
            mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, S_MD), idle(S_MD), idle(S_MD),
            idle(S_RUN)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL muldiv[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_branch();
    seq = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, S_FL),
            mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b1, S_RUN), idle(S_RUN),
            mk(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, S_LS),
            mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, S_FL), idle(S_RUN),
            mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_MD), idle(S_MD),
            mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, S_FL), idle(S_RUN), idle(S_RUN)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL branch[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    stim_t lu, md;
    lu = mk(1'b1, 5'd4, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0, S_LS);
    md = mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_MD);
    seq = '{lu, lu, lu, lu, idle(S_RUN), md, md, md, md, md, md,
            idle(S_MD), idle(S_MD), idle(S_MD), idle(S_RUN)};
    seq[1].st = S_RUN;
    seq[3].st = S_RUN;
    seq[9].st = S_RUN;
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid_wait();
    seq = '{mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_MD), idle(S_MD)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL mid_wait_pre[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (obs() !== outv(S_RUN)) begin
      errors++; $display("FAIL mid_wait_async: got %b expected %b", obs(), outv(S_RUN));
    end
    seq = '{idle(S_RUN), idle(S_RUN), idle(S_RUN), idle(S_RUN)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]); reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL mid_wait_post[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_stall_count();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    seq = '{mk(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, S_LS), idle(S_RUN),
            mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, S_MD), idle(S_MD), idle(S_MD), idle(S_MD),
            idle(S_RUN)};
    foreach (seq[i]) begin
      @(negedge clk); apply(seq[i]);
      @(posedge clk); #1;
      checks++;
      if (obs() !== exp_q[0]) begin
        errors++; $display("FAIL count_seq[%0d]: got %b expected %b", i, obs(), exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    checks++;
    if (bus.stallCycles !== 16'(EXP_CNT)) begin
      errors++; $display("FAIL stall_count: got %0d expected %0d", bus.stallCycles, EXP_CNT);
    end
    @(negedge clk); bus.clearStallCount = 1'b1;
    @(negedge clk); bus.clearStallCount = 1'b0;
    checks++;
    if (bus.stallCycles !== 16'd0) begin
      errors++; $display("FAIL stall_clear: got %0d expected 0", bus.stallCycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch();
    test_back_to_back();
    test_reset_mid_wait();
    test_stall_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
